servo_step_ctrl: RTL and testbench

//   Upstream position sequencer for servo_pwm. Accepts target-position commands over a

---
 rtl/servo_step_if.sv | 27 ++
 rtl/servo_step_ctrl.sv | 126 ++++++++++++
 tb/tb_servo_step_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_step_if.sv
// Command and status bundle between a position sequencer and its upstream.
//
// Handshake: a command transfers on any rising clk edge where cmd_valid and
// cmd_ready are both 1. While cmd_valid=1 and cmd_ready=0 the upstream holds
// cmd_valid high; cmd_target may change, but it has no effect until ready.
interface servo_step_if;
    logic       cmd_valid;
    logic [2:0] cmd_target;
    logic       cmd_ready;
    logic       abort;
    logic [2:0] value;
    logic       busy;
    logic       done;
    logic       err;

    // Upstream side: issues commands and aborts, observes status
    modport master (
        output cmd_valid, cmd_target, abort,
        input  cmd_ready, value, busy, done, err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_target, abort,
        output cmd_ready, value, busy, done, err
    );
endinterface

// File: rtl/servo_step_ctrl.sv
// Servo position sequencer: accepts a target code and slews the 3-bit servo
// position code toward it one step per dwell period. Code 0 is "PWM off",
// 1..5 are positions and 6..7 are illegal targets that are dropped with err.
module servo_step_ctrl #(
    parameter int DWELL_CYCLES = 10000000,
    parameter int CNT_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    servo_step_if.slave      bus,
    output logic             o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    localparam logic [2:0]       MAX_POS    = 3'd5;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_target;
    logic [2:0]       r_value;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_target_nxt;
    logic [2:0]       w_value_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_cmd_ready;

    // One code toward the target; only called when cur != tgt and neither is 0
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        return (tgt > cur) ? cur + 3'd1 : cur - 3'd1;
    endfunction

    assign w_cmd_ready   = (r_state == S_IDLE);
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.value     = r_value;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign o_dbg_state   = r_state;
    assign o_dbg_cnt     = r_cnt;

    // Next-state, dwell counter and position stepping
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_value_nxt  = r_value;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort is meaningless here; only a command moves us
                if (bus.cmd_valid && w_cmd_ready) begin
                    if (bus.cmd_target > MAX_POS) begin
                        w_err_nxt = 1'b1;
                    end else if (bus.cmd_target == r_value) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_target_nxt = bus.cmd_target;
                        w_cnt_nxt    = CNT_RELOAD;
                        w_state_nxt  = S_DWELL;
                        // From or to "off" there is no known position to slew through
                        if (r_value == 3'd0 || bus.cmd_target == 3'd0) begin
                            w_value_nxt = bus.cmd_target;
                        end else begin
                            w_value_nxt = step_toward(r_value, bus.cmd_target);
                        end
                    end
                end
            end
            S_DWELL: begin
                // abort wins over a step or finish landing on the same edge
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    if (r_value == r_target) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_value_nxt = step_toward(r_value, r_target);
                        w_cnt_nxt   = CNT_RELOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset turns the servo off immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_target <= 3'd0;
            r_value  <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_value  <= w_value_nxt;
            r_busy   <= (w_state_nxt == S_DWELL);
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_servo_step_ctrl.sv
// Directed bench for servo_step_ctrl with a short dwell so whole moves fit
// in a few dozen cycles. Inputs change and outputs are sampled on negedge.
module tb_servo_step_ctrl;

    localparam int DW    = 4;
    localparam int CW    = 4;
    localparam int LIMIT = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          dbg_state;
    logic [CW-1:0] dbg_cnt;

    servo_step_if u_if ();

    servo_step_ctrl #(
        .DWELL_CYCLES (DW),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_if.slave),
        .o_dbg_state (dbg_state),
        .o_dbg_cnt   (dbg_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tgt;
        logic [2:0] final_val;
        int         lat;
        logic       is_err;
    } move_t;

    move_t      moves [12];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q [$];
    logic       mon_en   = 1'b0;
    logic [2:0] mon_prev = 3'd0;
    logic [2:0] model_val = 3'd0;
    int         cnt_max  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected sequence of value codes for a move from cur to tgt
    task automatic push_expected(input logic [2:0] cur, input logic [2:0] tgt);
        logic [2:0] v;
        v = cur;
        if (tgt > 3'd5 || tgt == cur) return;
        if (cur == 3'd0 || tgt == 3'd0) begin
            exp_q.push_back(tgt);
            return;
        end
        while (v != tgt) begin
            v = (tgt > v) ? v + 3'd1 : v - 3'd1;
            exp_q.push_back(v);
        end
    endtask

    // Scoreboard: every change of value must match the next expected code
    always @(negedge clk) begin : mon
        logic [2:0] exp_v;
        logic       legal;
        if (mon_en) begin
            if (int'(dbg_cnt) > cnt_max) cnt_max = int'(dbg_cnt);
            if (u_if.value !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL value_seq: got unexpected change to %0d, required no change", u_if.value);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("value_seq", int'(u_if.value), int'(exp_v));
                end
                legal = (u_if.value == mon_prev + 3'd1) || (mon_prev == u_if.value + 3'd1) ||
                        (u_if.value == 3'd0) || (mon_prev == 3'd0);
                check("value_step_legal", int'(legal), 1);
                check("value_range", int'(u_if.value <= 3'd5), 1);
                mon_prev = u_if.value;
            end
        end
    end

    // Wait for done; returns cycles counted from the negedge after acceptance
    task automatic wait_done(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!u_if.done && n < LIMIT) begin
            if (!u_if.busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    // Driver: issue one command and check the complete outcome
    task automatic run_move(input logic [2:0] tgt, input logic [2:0] fin,
                            input int lat, input logic is_err);
        int   n;
        logic busy_ok;
        @(negedge clk);
        check("ready_before_cmd", int'(u_if.cmd_ready), 1);
        push_expected(model_val, tgt);
        u_if.cmd_valid  = 1'b1;
        u_if.cmd_target = tgt;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        if (is_err) begin
            check("err_pulse", int'(u_if.err), 1);
            check("err_no_done", int'(u_if.done), 0);
            check("err_value_held", int'(u_if.value), int'(fin));
            check("err_not_busy", int'(u_if.busy), 0);
            @(negedge clk);
            check("err_one_cycle", int'(u_if.err), 0);
        end else begin
            wait_done(n, busy_ok);
            check("done_latency", n, lat);
            check("final_value", int'(u_if.value), int'(fin));
            check("busy_during_move", int'(busy_ok), 1);
            check("busy_at_done", int'(u_if.busy), 0);
            check("ready_at_done", int'(u_if.cmd_ready), 1);
            check("no_err_on_move", int'(u_if.err), 0);
            @(negedge clk);
            check("done_one_cycle", int'(u_if.done), 0);
        end
        check("queue_drained", exp_q.size(), 0);
        model_val = fin;
    endtask

    initial begin
        int   n;
        int   done_cnt;
        logic busy_ok;

        moves[0]  = '{3'd3, 3'd3,  4, 1'b0};  // jump from off
        moves[1]  = '{3'd1, 3'd1,  8, 1'b0};  // 3->2->1
        moves[2]  = '{3'd5, 3'd5, 16, 1'b0};  // 1->2->3->4->5
        moves[3]  = '{3'd4, 3'd4,  4, 1'b0};  // 5->4
        moves[4]  = '{3'd4, 3'd4,  0, 1'b0};  // already there
        moves[5]  = '{3'd6, 3'd4,  0, 1'b1};  // illegal
        moves[6]  = '{3'd7, 3'd4,  0, 1'b1};  // illegal
        moves[7]  = '{3'd0, 3'd0,  4, 1'b0};  // jump to off
        moves[8]  = '{3'd0, 3'd0,  0, 1'b0};  // off -> off
        moves[9]  = '{3'd5, 3'd5,  4, 1'b0};  // jump from off to top
        moves[10] = '{3'd3, 3'd3,  8, 1'b0};  // 5->4->3
        moves[11] = '{3'd0, 3'd0,  4, 1'b0};  // 3 -> off

        rst             = 1'b1;
        u_if.cmd_valid  = 1'b0;
        u_if.cmd_target = 3'd0;
        u_if.abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", int'(u_if.value), 0);
        check("rst_busy", int'(u_if.busy), 0);
        check("rst_done", int'(u_if.done), 0);
        check("rst_err", int'(u_if.err), 0);
        check("rst_cnt", int'(dbg_cnt), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(u_if.cmd_ready), 1);
        mon_prev = 3'd0;
        mon_en   = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_move(moves[i].tgt, moves[i].final_val, moves[i].lat, moves[i].is_err);
        end

        // Abort landing on the same edge as a step: value holds, no done
        run_move(3'd5, 3'd5, 4, 1'b0);
        @(negedge clk);
        exp_q.push_back(3'd4);
        u_if.cmd_valid  = 1'b1;
        u_if.cmd_target = 3'd1;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        check("abort_first_step", int'(u_if.value), 4);
        check("abort_busy", int'(u_if.busy), 1);
        repeat (3) @(negedge clk);
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.abort = 1'b0;
        check("abort_value_held", int'(u_if.value), 4);
        check("abort_busy_clear", int'(u_if.busy), 0);
        check("abort_state_idle", int'(dbg_state), 0);
        check("abort_cnt_clear", int'(dbg_cnt), 0);
        check("abort_ready", int'(u_if.cmd_ready), 1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (u_if.done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_value_stays", int'(u_if.value), 4);
        model_val = 3'd4;
        run_move(3'd2, 3'd2, 8, 1'b0);

        // abort while idle does nothing
        @(negedge clk);
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.abort = 1'b0;
        check("idle_abort_state", int'(dbg_state), 0);
        check("idle_abort_value", int'(u_if.value), 2);
        check("idle_abort_done", int'(u_if.done), 0);

        // Command held through a move, target changed while not ready
        @(negedge clk);
        push_expected(3'd2, 3'd4);
        u_if.cmd_valid  = 1'b1;
        u_if.cmd_target = 3'd4;
        @(negedge clk);
        u_if.cmd_target = 3'd1;
        check("held_first_step", int'(u_if.value), 3);
        check("held_not_ready", int'(u_if.cmd_ready), 0);
        wait_done(n, busy_ok);
        check("held_done_latency", n, 8);
        check("held_value_at_done", int'(u_if.value), 4);
        check("held_busy_during", int'(busy_ok), 1);
        check("held_ready_at_done", int'(u_if.cmd_ready), 1);
        push_expected(3'd4, 3'd1);
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        check("held_accepted_step", int'(u_if.value), 3);
        check("held_accepted_busy", int'(u_if.busy), 1);
        wait_done(n, busy_ok);
        check("held2_done_latency", n, 12);
        check("held2_final", int'(u_if.value), 1);
        check("held2_queue_drained", exp_q.size(), 0);
        model_val = 3'd1;

        // Reset in the middle of a dwell turns the servo off at that edge
        @(negedge clk);
        exp_q.push_back(3'd2);
        u_if.cmd_valid  = 1'b1;
        u_if.cmd_target = 3'd3;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        check("midrst_step", int'(u_if.value), 2);
        @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("midrst_value", int'(u_if.value), 0);
        check("midrst_busy", int'(u_if.busy), 0);
        check("midrst_done", int'(u_if.done), 0);
        check("midrst_cnt", int'(dbg_cnt), 0);
        rst = 1'b0;
        exp_q.delete();
        mon_prev  = 3'd0;
        model_val = 3'd0;
        mon_en    = 1'b1;
        run_move(3'd3, 3'd3, 4, 1'b0);

        check("cnt_max_is_dwell_minus_1", cnt_max, DW - 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
